// File: rtl/display_pkg.sv
// display_pkg: seven-segment glyph constants and anode helper shared by display blocks.
package display_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_TAB [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                          SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  function automatic logic [7:0] an_low(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction
endpackage

// File: rtl/display_mux_n_if.sv
// display_mux_n_if: digit/mask inputs and segment/anode outputs of the display scanner.
interface display_mux_n_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W = 4
);
  logic tick_fast;
  logic blink_state;
  logic lz_blank_en;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [BRIGHT_W-1:0] brightness;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [6:0] seg;
  logic [NUM_DIGITS-1:0] an;
  logic dp;
  modport master (
    output tick_fast, blink_state, lz_blank_en, blink_mask, dp_mask, brightness, digits,
    input seg, an, dp
  );
  modport slave (
    input tick_fast, blink_state, lz_blank_en, blink_mask, dp_mask, brightness, digits,
    output seg, an, dp
  );
endinterface

// File: rtl/seg7_encode.sv
// seg7_encode: 4-bit code to active-low g..a segments; codes 10..15 blank unless HEX_EN.
module seg7_encode
  import display_pkg::*;
#(
  parameter bit HEX_EN = 0
) (
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  assign seg_o = (!HEX_EN && code_i > 4'd9) ? SEG_BLANK : SEG_TAB[code_i];
endmodule

// File: rtl/display_mux_n.sv
// display_mux_n: time-multiplexes NUM_DIGITS digits onto one active-low segment bus
// with dead-time blanking, PWM dimming, blink, decimal point and leading-zero suppression.
module display_mux_n
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DEAD_CYCLES = 16,
  parameter int BRIGHT_W = 4,
  parameter bit HEX_EN = 0
) (
  input logic clk,
  input logic rst_n,
  display_mux_n_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = $clog2(DEAD_CYCLES + 2);
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("display_mux_n: NUM_DIGITS must be in 2..8");
  end
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [BRIGHT_W-1:0] pwm_q;
  logic [3:0] dig_q, dig_d;
  logic lz_q, lz_d, blink_q, blink_d, dpm_q, dpm_d, init_q;
  logic [NUM_DIGITS-1:0] lz_vec, an_d, an_q;
  logic [6:0] glyph, seg_d, seg_q;
  logic dp_d, dp_q, load, lit, bb;
  // digit i is a leading zero when it and every more significant digit are zero
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    assign lz_vec[i] = bus.lz_blank_en && (i != 0) && ((bus.digits >> (4 * i)) == '0);
  end
  seg7_encode #(.HEX_EN(HEX_EN)) u_enc (.code_i(dig_q), .seg_o(glyph));
  always_comb begin
    idx_d = bus.tick_fast ? ((idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1)) : idx_q;
    dead_d = bus.tick_fast ? DW'(DEAD_CYCLES) : ((dead_q != '0) ? dead_q - DW'(1) : dead_q);
    load = bus.tick_fast || !init_q;
    dig_d = load ? bus.digits[{idx_d, 2'b00} +: 4] : dig_q;
    lz_d = load ? lz_vec[idx_d] : lz_q;
    blink_d = load ? bus.blink_mask[idx_d] : blink_q;
    dpm_d = load ? bus.dp_mask[idx_d] : dpm_q;
    lit = (dead_q == '0) && ((&bus.brightness) || (pwm_q < bus.brightness));
    bb = blink_q && !bus.blink_state;
    an_d = lit ? NUM_DIGITS'(an_low(3'(idx_q))) : '1;
    seg_d = (!lit || lz_q || bb) ? SEG_BLANK : glyph;
    dp_d = !(lit && dpm_q && !bb);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      dead_q <= DW'(DEAD_CYCLES);
      pwm_q <= '0;
      dig_q <= '0;
      lz_q <= 1'b0;
      blink_q <= 1'b0;
      dpm_q <= 1'b0;
      init_q <= 1'b0;
      seg_q <= SEG_BLANK;
      an_q <= '1;
      dp_q <= 1'b1;
    end else begin
      idx_q <= idx_d;
      dead_q <= dead_d;
      pwm_q <= pwm_q + BRIGHT_W'(1);
      dig_q <= dig_d;
      lz_q <= lz_d;
      blink_q <= blink_d;
      dpm_q <= dpm_d;
      init_q <= 1'b1;
      seg_q <= seg_d;
      an_q <= an_d;
      dp_q <= dp_d;
    end
  end
  assign bus.seg = seg_q;
  assign bus.an = an_q;
  assign bus.dp = dp_q;
endmodule

// File: tb/tb_display_mux_n.sv
// tb_display_mux_n: two scanner configurations driven in lockstep and checked every cycle
// against an abstract model of the display rules.
module tb_display_mux_n;
  localparam int N = 4;
  localparam int BW = 4;
  localparam int DCA = 4;
  localparam int DCB = 0;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic tick, blink_state, lz_en;
  logic [N-1:0] blink_mask, dp_mask;
  logic [BW-1:0] bright;
  logic [4*N-1:0] digits;
  int total = 0;
  int fails = 0;
  display_mux_n_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) ifa ();
  display_mux_n_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) ifb ();
  assign ifa.tick_fast = tick;
  assign ifa.blink_state = blink_state;
  assign ifa.lz_blank_en = lz_en;
  assign ifa.blink_mask = blink_mask;
  assign ifa.dp_mask = dp_mask;
  assign ifa.brightness = bright;
  assign ifa.digits = digits;
  assign ifb.tick_fast = tick;
  assign ifb.blink_state = blink_state;
  assign ifb.lz_blank_en = lz_en;
  assign ifb.blink_mask = blink_mask;
  assign ifb.dp_mask = dp_mask;
  assign ifb.brightness = bright;
  assign ifb.digits = digits;
  display_mux_n #(.NUM_DIGITS(N), .DEAD_CYCLES(DCA), .BRIGHT_W(BW), .HEX_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  display_mux_n #(.NUM_DIGITS(N), .DEAD_CYCLES(DCB), .BRIGHT_W(BW), .HEX_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int dc [2] = '{DCA, DCB};
  bit hex [2] = '{1'b1, 1'b0};
  int m_idx [2], m_since [2], m_cycle [2], s_dig [2];
  bit s_lz [2], s_blink [2], s_dp [2], m_loaded [2];
  function automatic bit lz_of(int i);
    if (!lz_en || i == 0) return 1'b0;
    for (int j = i; j < N; j++) if (digits[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction
  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_idx[u] = 0; m_since[u] = 0; m_cycle[u] = 0; s_dig[u] = 0;
      s_lz[u] = 0; s_blink[u] = 0; s_dp[u] = 0; m_loaded[u] = 0;
    end
  endtask
  task automatic model_edge();
    for (int u = 0; u < 2; u++) begin
      if (tick) begin
        m_idx[u] = (m_idx[u] + 1) % N;
        m_since[u] = 0;
      end else m_since[u]++;
      if (tick || !m_loaded[u]) begin
        s_dig[u] = int'(digits[4*m_idx[u] +: 4]);
        s_lz[u] = lz_of(m_idx[u]);
        s_blink[u] = blink_mask[m_idx[u]];
        s_dp[u] = dp_mask[m_idx[u]];
        m_loaded[u] = 1;
      end
      m_cycle[u]++;
    end
  endtask
  task automatic expect_out(input int u, output logic [6:0] es, output logic [N-1:0] ea, output logic ed);
    bit on, blank_blink;
    int duty;
    duty = int'(bright);
    on = (m_since[u] >= dc[u]) && (duty == (1 << BW) - 1 || (m_cycle[u] % (1 << BW)) < duty);
    blank_blink = s_blink[u] && !blink_state;
    es = 7'h7F; ea = '1; ed = 1'b1;
    if (on) begin
      ea[m_idx[u]] = 1'b0;
      if (!s_lz[u] && !blank_blink) es = (s_dig[u] > 9 && !hex[u]) ? 7'h7F : glyph_tab[s_dig[u]];
      ed = !(s_dp[u] && !blank_blink);
    end
  endtask
  task automatic check(input string tag, input logic [6:0] s, input logic [N-1:0] a, input logic d,
                       input logic [6:0] xs, input logic [N-1:0] xa, input logic xd);
    total += 3;
    assert (s === xs) else begin fails++; $error("FAIL %s seg got %b want %b t=%0t", tag, s, xs, $time); end
    assert (a === xa) else begin fails++; $error("FAIL %s an got %b want %b t=%0t", tag, a, xa, $time); end
    assert (d === xd) else begin fails++; $error("FAIL %s dp got %b want %b t=%0t", tag, d, xd, $time); end
  endtask
  task automatic cycle();
    logic [6:0] es [2];
    logic [N-1:0] ea [2];
    logic ed [2];
    for (int u = 0; u < 2; u++) expect_out(u, es[u], ea[u], ed[u]);
    @(posedge clk);
    model_edge();
    #1;
    check("cfg_a", ifa.seg, ifa.an, ifa.dp, es[0], ea[0], ed[0]);
    check("cfg_b", ifb.seg, ifb.an, ifb.dp, es[1], ea[1], ed[1]);
  endtask
  task automatic run(input int n);
    repeat (n) cycle();
  endtask
  task automatic tick_run(input int gap);
    tick = 1; cycle(); tick = 0; run(gap - 1);
  endtask
  initial begin
    tick = 0; blink_state = 1; lz_en = 0; blink_mask = '0; dp_mask = '0;
    bright = '1; digits = 16'h1234;
    model_reset();
    #12;
    check("reset_a", ifa.seg, ifa.an, ifa.dp, 7'h7F, '1, 1'b1);
    check("reset_b", ifb.seg, ifb.an, ifb.dp, 7'h7F, '1, 1'b1);
    @(negedge clk);
    rst_n = 1;
    run(10);
    repeat (9) tick_run(20);
    digits = 16'h0050; lz_en = 1;
    repeat (5) tick_run(12);
    digits = 16'h0000;
    repeat (5) tick_run(12);
    digits = 16'h8A9C; lz_en = 0; blink_mask = 4'b1100; dp_mask = 4'b0100;
    for (int k = 0; k < 16; k++) begin
      blink_state = k[1];
      tick_run(9);
    end
    blink_mask = '0; blink_state = 1;
    bright = 4'd4;
    repeat (4) tick_run(40);
    bright = 4'd0;
    repeat (4) tick_run(20);
    bright = '1;
    tick_run(2); tick_run(2); run(10);
    run(20);
    #3 rst_n = 0;
    #1;
    check("async_rst_a", ifa.seg, ifa.an, ifa.dp, 7'h7F, '1, 1'b1);
    check("async_rst_b", ifb.seg, ifb.an, ifb.dp, 7'h7F, '1, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    run(12);
    for (int k = 0; k < 3000; k++) begin
      tick = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) digits = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 99) == 0) bright = ($urandom_range(0, 3) == 0) ? '1 : 4'($urandom);
      if ($urandom_range(0, 29) == 0) blink_state = ~blink_state;
      cycle();
    end
    tick = 0;
    run(8);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
